disp_refresh_sched: RTL and testbench

DISP_REFRESH_SCHED -- requirements
Module: disp_refresh_sched

---
 rtl/disp_refresh_sched_pkg.sv | 24 ++
 rtl/disp_refresh_sched_dff.sv | 18 +
 rtl/disp_refresh_sched_timer.sv | 24 ++
 rtl/disp_refresh_sched.sv | 119 +++++++++++
 tb/tb_disp_refresh_sched.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/disp_refresh_sched_pkg.sv
// Shared display package: scheduler state codes and default timing constants,
// used by the refresh scheduler and the shift engine controller.
package disp_refresh_sched_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_DISP  = 3'd3,
        ST_GAP   = 3'd4,
        ST_HOLD  = 3'd5
    } sched_state_t;

    localparam int          CNT_W        = 16;
    localparam logic [15:0] DEF_DISP_CYC = 16'd1000;
    localparam logic [15:0] DEF_GAP_CYC  = 16'd20;
    localparam logic [15:0] DEF_TO_CYC   = 16'd200;

    // Terminal count for a phase that lasts 'cyc' cycles (cyc >= 1).
    function automatic logic [CNT_W-1:0] last_cnt(input logic [CNT_W-1:0] cyc);
        return cyc - 16'd1;
    endfunction

endpackage

// File: rtl/disp_refresh_sched_dff.sv
// Generic D-flip-flop register with synchronous active-high reset.
module dff_sr #(
    parameter int         W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Capture d every cycle; reset wins.
    always_ff @(posedge clk) begin
        if (rst) q <= RST_VAL;
        else     q <= d;
    end

endmodule

// File: rtl/disp_refresh_sched_timer.sv
// sched_timer: 16-bit loadable up-counter with terminal-count compare.
module sched_timer
    import disp_refresh_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             inc,
    input  logic [CNT_W-1:0] term,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    // Load has priority over increment; plain wrap, never saturates.
    always_ff @(posedge clk) begin
        if (rst)       cnt <= '0;
        else if (load) cnt <= load_val;
        else if (inc)  cnt <= cnt + 16'd1;
    end

    assign tc = (cnt == term);

endmodule

// File: rtl/disp_refresh_sched.sv
// Display refresh scheduler: walks rows through LOAD/SHIFT/DISP/GAP and
// lends the shift engine and character RAM to the host at row boundaries.
module disp_refresh_sched
    import disp_refresh_sched_pkg::*;
#(
    parameter int          ROWS     = 2,
    parameter logic [15:0] DISP_CYC = DEF_DISP_CYC,
    parameter logic [15:0] GAP_CYC  = DEF_GAP_CYC,
    parameter logic [15:0] TO_CYC   = DEF_TO_CYC
) (
    input  logic            C,
    input  logic            R,
    input  logic            EN,
    output logic            Start_Y,
    input  logic            Done_Y,
    output logic [1:0]      Row,
    output logic [ROWS-1:0] Grid,
    input  logic            HReq,
    output logic            HGnt,
    output logic            Err
);

    sched_state_t     state, nxt;
    logic [2:0]       state_q;
    logic [CNT_W-1:0] cnt, term;
    logic             tc, clr, inc;
    logic             gap_exit, timeout;
    logic [1:0]       row_adv;

    dff_sr #(.W(3), .RST_VAL(ST_IDLE)) u_state (
        .clk (C),
        .rst (R),
        .d   (nxt),
        .q   (state_q)
    );

    assign state = sched_state_t'(state_q);

    // Every state change restarts the phase counter; only timed phases count.
    assign clr = (nxt != state);
    assign inc = (state == ST_SHIFT) || (state == ST_DISP) || (state == ST_GAP);

    // Terminal count of the phase currently being timed.
    always_comb begin
        term = '0;
        case (state)
            ST_SHIFT: term = last_cnt(TO_CYC);
            ST_DISP:  term = last_cnt(DISP_CYC);
            ST_GAP:   term = last_cnt(GAP_CYC);
            default:  term = '0;
        endcase
    end

    sched_timer u_timer (
        .clk      (C),
        .rst      (R),
        .load     (clr),
        .load_val ('0),
        .inc      (inc),
        .term     (term),
        .cnt      (cnt),
        .tc       (tc)
    );

    assign row_adv = (Row == 2'(ROWS - 1)) ? 2'd0 : Row + 2'd1;

    // Next-state logic; HReq is only looked at in IDLE and at GAP exit.
    always_comb begin
        nxt      = state;
        gap_exit = 1'b0;
        timeout  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (HReq)    nxt = ST_HOLD;
                else if (EN) nxt = ST_LOAD;
            end
            ST_LOAD:  nxt = ST_SHIFT;
            ST_SHIFT: begin
                if (Done_Y) nxt = ST_DISP;
                else if (tc) begin
                    nxt     = ST_GAP;
                    timeout = 1'b1;
                end
            end
            ST_DISP: if (tc) nxt = ST_GAP;
            ST_GAP: begin
                if (tc) begin
                    gap_exit = 1'b1;
                    if (HReq)    nxt = ST_HOLD;
                    else if (EN) nxt = ST_LOAD;
                    else         nxt = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!HReq) nxt = EN ? ST_LOAD : ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // Registered outputs follow the state being entered, so they line up
    // with the state register and never see Done_Y/HReq combinationally.
    always_ff @(posedge C) begin
        if (R) begin
            Start_Y <= 1'b0;
            Grid    <= '0;
            HGnt    <= 1'b0;
            Err     <= 1'b0;
            Row     <= 2'd0;
        end else begin
            Start_Y <= (nxt == ST_LOAD);
            HGnt    <= (nxt == ST_HOLD);
            Grid    <= (nxt == ST_DISP) ? (ROWS'(1) << Row) : '0;
            if (gap_exit) Row <= row_adv;
            if (timeout)  Err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_disp_refresh_sched.sv
// Directed bench for disp_refresh_sched with short timing parameters.
module tb_disp_refresh_sched;

    logic       C = 1'b0;
    logic       R, EN, Done_Y, HReq;
    logic       Start_Y, HGnt, Err;
    logic [1:0] Row;
    logic [1:0] Grid;

    int total = 0;
    int bad   = 0;

    disp_refresh_sched #(
        .ROWS     (2),
        .DISP_CYC (16'd4),
        .GAP_CYC  (16'd2),
        .TO_CYC   (16'd8)
    ) dut (
        .C       (C),
        .R       (R),
        .EN      (EN),
        .Start_Y (Start_Y),
        .Done_Y  (Done_Y),
        .Row     (Row),
        .Grid    (Grid),
        .HReq    (HReq),
        .HGnt    (HGnt),
        .Err     (Err)
    );

    always #5 C = ~C;

    typedef struct {
        logic       r, en, d, h;
        logic       s;
        logic [1:0] g;
        logic [1:0] row;
        logic       hg, err;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic r, logic en, logic d, logic h,
                                logic s, logic [1:0] g, logic [1:0] row,
                                logic hg, logic err);
        vec_t v;
        v.r = r; v.en = en; v.d = d; v.h = h;
        v.s = s; v.g = g; v.row = row; v.hg = hg; v.err = err;
        vq.push_back(v);
    endfunction

    task automatic step();
        @(posedge C);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, act, exp);
        end
    endtask

    initial begin
        R = 1'b1; EN = 1'b0; Done_Y = 1'b0; HReq = 1'b0;

        // Normal scan, two rows, 10-cycle period.
        add(1,0,0,0, 0,2'b00,0,0,0);                              // reset
        add(0,1,0,0, 1,2'b00,0,0,0);                              // LOAD row 0
        for (int i = 0; i < 3; i++) add(0,1,0,0, 0,2'b00,0,0,0);  // SHIFT
        add(0,1,1,0, 0,2'b01,0,0,0);                              // Done -> DISP
        for (int i = 0; i < 3; i++) add(0,1,0,0, 0,2'b01,0,0,0);
        for (int i = 0; i < 2; i++) add(0,1,0,0, 0,2'b00,0,0,0);  // GAP
        add(0,1,0,0, 1,2'b00,1,0,0);                              // LOAD row 1
        for (int i = 0; i < 3; i++) add(0,1,0,0, 0,2'b00,1,0,0);
        add(0,1,1,0, 0,2'b10,1,0,0);
        for (int i = 0; i < 3; i++) add(0,1,0,0, 0,2'b10,1,0,0);
        for (int i = 0; i < 2; i++) add(0,1,0,0, 0,2'b00,1,0,0);
        add(0,1,0,0, 1,2'b00,0,0,0);                              // wrap to row 0
        // Shift timeout: 8 SHIFT cycles, then Err and GAP without grid.
        for (int i = 0; i < 8; i++) add(0,1,0,0, 0,2'b00,0,0,0);
        for (int i = 0; i < 2; i++) add(0,1,0,0, 0,2'b00,0,0,1);
        add(0,1,0,0, 1,2'b00,1,0,1);                              // row 1 next
        add(0,1,0,0, 0,2'b00,1,0,1);                              // SHIFT
        // Reset mid-SHIFT with Err set, then spurious Done in IDLE.
        add(1,1,0,0, 0,2'b00,0,0,0);
        add(0,0,1,0, 0,2'b00,0,0,0);
        add(0,0,1,0, 0,2'b00,0,0,0);
        add(0,0,0,0, 0,2'b00,0,0,0);
        add(0,1,0,0, 1,2'b00,0,0,0);

        foreach (vq[i]) begin
            R = vq[i].r; EN = vq[i].en; Done_Y = vq[i].d; HReq = vq[i].h;
            step();
            total++;
            if ({Start_Y, Grid, Row, HGnt, Err} !=
                {vq[i].s, vq[i].g, vq[i].row, vq[i].hg, vq[i].err}) begin
                bad++;
                $display("FAIL vec%0d got s=%0b g=%b row=%0d hg=%0b err=%0b want s=%0b g=%b row=%0d hg=%0b err=%0b",
                         i, Start_Y, Grid, Row, HGnt, Err,
                         vq[i].s, vq[i].g, vq[i].row, vq[i].hg, vq[i].err);
            end
        end
        Done_Y = 1'b0;

        // Host request raised during DISP waits for the row boundary.
        R = 1'b1; EN = 1'b0; HReq = 1'b0; step();
        R = 1'b0; EN = 1'b1; step();
        chk("hold_start", Start_Y, 1);
        for (int i = 0; i < 3; i++) step();
        Done_Y = 1'b1; step(); Done_Y = 1'b0;
        chk("hold_disp_grid", Grid, 1);
        HReq = 1'b1; step();
        chk("hold_no_gnt_disp", HGnt, 0);
        chk("hold_grid_kept", Grid, 1);
        step(); step();
        chk("hold_disp_last", Grid, 1);
        step();
        chk("hold_no_gnt_gap0", HGnt, 0);
        chk("hold_gap0_grid", Grid, 0);
        step();
        chk("hold_no_gnt_gap1", HGnt, 0);
        step();
        chk("hold_gnt", HGnt, 1);
        chk("hold_no_start", Start_Y, 0);
        chk("hold_row", Row, 1);
        step();
        chk("hold_gnt_kept", HGnt, 1);
        HReq = 1'b0; step();
        chk("hold_gnt_drop", HGnt, 0);
        chk("hold_resume_start", Start_Y, 1);
        chk("hold_resume_row", Row, 1);

        // EN dropped mid-DISP; stray Done in DISP/GAP is ignored.
        for (int i = 0; i < 3; i++) step();
        Done_Y = 1'b1; step(); Done_Y = 1'b0;
        chk("en_disp_grid", Grid, 2);
        EN = 1'b0; step();
        Done_Y = 1'b1; step(); Done_Y = 1'b0;
        step();
        chk("en_disp_last", Grid, 2);
        Done_Y = 1'b1; step(); Done_Y = 1'b0;
        chk("en_gap_grid", Grid, 0);
        step();
        chk("en_gap1_start", Start_Y, 0);
        step();
        chk("en_idle_row", Row, 0);
        begin
            int seen = 0;
            for (int i = 0; i < 12; i++) begin
                step();
                if (Start_Y || Grid != 2'b00) seen++;
            end
            chk("en_idle_quiet", seen, 0);
        end
        chk("err_still_clear", Err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
